i2c_target_rx: RTL

//   I2C target (responder) receiver, clocked on CLK. Oversamples the open-drain SCL/SDA

---
 rtl/i2c_target_rx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_rx.sv
// I2C write-only target: oversampled SCL/SDA, START/STOP decode, 7-bit address match,
// ACK generation and capture of up to MAX_BYTES bytes. Optional I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_rx #(
  parameter logic [6:0] ADDR       = 7'h60,
  parameter int         MAX_BYTES  = 4,
  parameter int         FILTER_LEN = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCL_IN,
  input  logic        SDA_IN,
  output logic        SDA_OE,
  output logic [31:0] RX_DATA,
  output logic [2:0]  RX_COUNT,
  output logic        RX_VALID,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  if (MAX_BYTES < 1 || MAX_BYTES > 4 || FILTER_LEN < 1) begin : g_param_check
    $error("i2c_target_rx: MAX_BYTES must be 1..4 and FILTER_LEN >= 1");
  end

  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_f, sda_f, scl_q, sda_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_s1 <= SCL_IN;
      scl_s2 <= scl_s1;
      sda_s1 <= SDA_IN;
      sda_s2 <= sda_s1;
      scl_q  <= scl_f;
      sda_q  <= sda_f;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // A new level is taken only after FILTER_LEN consecutive differing samples.
  logic [7:0] scl_run, sda_run;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_run <= '0;
      sda_run <= '0;
    end else begin
      if (scl_s2 == scl_f) begin
        scl_run <= '0;
      end else if (scl_run == 8'(FILTER_LEN - 1)) begin
        scl_f   <= scl_s2;
        scl_run <= '0;
      end else begin
        scl_run <= scl_run + 8'd1;
      end
      if (sda_s2 == sda_f) begin
        sda_run <= '0;
      end else if (sda_run == 8'(FILTER_LEN - 1)) begin
        sda_f   <= sda_s2;
        sda_run <= '0;
      end else begin
        sda_run <= sda_run + 8'd1;
      end
    end
  end
`else
  always_comb begin
    scl_f = scl_s2;
    sda_f = sda_s2;
  end
`endif

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  state_t      state, state_n;
  logic        sda_oe_q, oe_n, busy_q, busy_n, frame_end;
  logic [7:0]  shreg, rx_byte;
  logic [3:0]  bit_cnt;   // 0..7 data bits, 8 = byte done, 9 = skip NACK slot
  logic [2:0]  byte_cnt;
  logic [31:0] rx_buf;
  logic        ack_pend, addr_match;

  assign rx_byte    = {shreg[6:0], sda_f};
  assign addr_match = (shreg[7:1] == ADDR) && !shreg[0];

  always_comb begin
    state_n   = state;
    oe_n      = sda_oe_q;
    busy_n    = busy_q;
    frame_end = (start_det || stop_det) && (byte_cnt != 3'd0);
    if (start_det) begin
      state_n = S_ADDR;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (stop_det) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        S_ADDR: if (scl_fall && bit_cnt == 4'd8) begin
          if (addr_match) begin
            state_n = S_ADDR_ACK;
            oe_n    = 1'b1;
            busy_n  = 1'b1;
          end else begin
            state_n = S_IGNORE;
            oe_n    = 1'b0;
          end
        end
        S_ADDR_ACK, S_DATA_ACK: if (scl_fall) begin
          state_n = S_DATA;
          oe_n    = 1'b0;
        end
        S_DATA: if (scl_fall && bit_cnt == 4'd8 && ack_pend) begin
          state_n = S_DATA_ACK;
          oe_n    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      RX_DATA  <= '0;
      RX_COUNT <= '0;
      RX_VALID <= 1'b0;
      OVERRUN  <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx_buf   <= '0;
      ack_pend <= 1'b0;
    end else begin
      state    <= state_n;
      sda_oe_q <= oe_n;
      busy_q   <= busy_n;
      RX_VALID <= frame_end;
      if (frame_end) begin
        RX_DATA  <= rx_buf;
        RX_COUNT <= byte_cnt;
      end
      if (start_det || stop_det) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        rx_buf   <= '0;
        ack_pend <= 1'b0;
        if (start_det) OVERRUN <= 1'b0;
      end else if (scl_rise && (state == S_ADDR || state == S_DATA)) begin
        if (bit_cnt == 4'd9) begin
          bit_cnt <= '0;
        end else if (bit_cnt < 4'd8) begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 4'd1;
          if (state == S_DATA && bit_cnt == 4'd7) begin
            if (byte_cnt < 3'(MAX_BYTES)) begin
              rx_buf   <= rx_buf | ({rx_byte, 24'h0} >> {byte_cnt, 3'b000});
              byte_cnt <= byte_cnt + 3'd1;
              ack_pend <= 1'b1;
            end else begin
              OVERRUN  <= 1'b1;
              ack_pend <= 1'b0;
            end
          end
        end
      end else if (scl_fall && bit_cnt == 4'd8) begin
        // An overflowing byte lets the master clock its NACK slot unsampled.
        bit_cnt <= (state == S_DATA && !ack_pend) ? 4'd9 : 4'd0;
      end
    end
  end

  // Reset gates the pull-down directly so SDA is freed without waiting for a clock.
  assign SDA_OE    = sda_oe_q & ~RESET;
  assign BUSY      = busy_q;
  assign state_dbg = state;

endmodule
